fan_speed_sched: RTL

FAN_SPEED_SCHED -- requirements
Module: fan_speed_sched

---
 rtl/fan_speed_sched_if.sv | 23 ++
 rtl/fan_speed_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fan_speed_sched_if.sv
// Signal bundle between the fan speed scheduler and its environment:
// button/timer/ultrasonic inputs and the duty/level/indicator outputs.
interface fan_speed_sched_if;
  logic        btn_speed;
  logic        timer_expired;
  logic [11:0] distance;
  logic        dist_valid;
  logic [7:0]  duty;
  logic [1:0]  level;
  logic        motor_sw;
  logic [2:0]  motor_led;
  logic [1:0]  state;

  modport master (
    output btn_speed, timer_expired, distance, dist_valid,
    input  duty, level, motor_sw, motor_led, state
  );

  modport slave (
    input  btn_speed, timer_expired, distance, dist_valid,
    output duty, level, motor_sw, motor_led, state
  );
endinterface

// File: rtl/fan_speed_sched.sv
// Fan speed scheduler: cycles speed levels, ramps the PWM duty toward the level
// target, stops hard on a close ultrasonic reading and ramps down on timer expiry.
module fan_speed_sched #(
  parameter int TICK_CYC  = 1_000_000,
  parameter int RAMP_STEP = 8,
  parameter int PROX_CM   = 10,
  parameter int HYST_CM   = 2
) (
  input  logic              clk,
  input  logic              reset_p,
  fan_speed_sched_if.slave  bus
);

  localparam int          TW        = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);
  localparam logic [8:0]  STEP9     = 9'(RAMP_STEP);
  localparam logic [11:0] NEAR_CM   = 12'(PROX_CM);
  localparam logic [11:0] FAR_CM    = 12'(PROX_CM + HYST_CM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2,
    PROX = 2'd3
  } state_t;

  state_t          cur, nxt;
  logic [1:0]      level_q, level_d;
  logic [7:0]      duty_q, duty_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [1:0]      far_q, far_d;
  logic            sw_q;
  logic [2:0]      led_q;
  logic [7:0]      tgt;
  logic            tick, close_rd, far_rd, near_rd;

  function automatic logic [7:0] target_of(input logic [1:0] l);
    case (l)
      2'd1:    return 8'd85;
      2'd2:    return 8'd170;
      2'd3:    return 8'd255;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] led_of(input logic [1:0] l);
    case (l)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // The 9th bit catches carry past 255 and borrow below 0 before clamping.
  function automatic logic [7:0] ramp_to(input logic [7:0] d, input logic [7:0] t);
    logic [8:0] up, dn;
    up = {1'b0, d} + STEP9;
    dn = {1'b0, d} - STEP9;
    if (d < t)
      return (up >= {1'b0, t}) ? t : up[7:0];
    else if (d > t)
      return (dn[8] || dn <= {1'b0, t}) ? t : dn[7:0];
    else
      return d;
  endfunction

  assign tick     = (tick_q == TICK_LAST);
  assign close_rd = bus.dist_valid && (bus.distance != 12'd0) && (bus.distance < NEAR_CM);
  assign far_rd   = bus.dist_valid && (bus.distance >= FAR_CM) && (bus.distance != 12'd0);
  assign near_rd  = bus.dist_valid && (bus.distance != 12'd0) && !far_rd;

  always_comb begin
    nxt     = cur;
    level_d = level_q;
    duty_d  = duty_q;
    tick_d  = '0;
    far_d   = '0;
    tgt     = '0;
    case (cur)
      IDLE: begin
        duty_d = '0;
        if (bus.btn_speed && !bus.timer_expired) begin
          level_d = 2'd1;
          nxt     = RAMP;
        end
      end
      RAMP: begin
        tick_d = tick ? '0 : tick_q + TW'(1);
        if (bus.timer_expired)
          level_d = 2'd0;
        else if (close_rd && level_q != 2'd0) begin
          nxt    = PROX;
          duty_d = '0;
        end else if (bus.btn_speed)
          level_d = level_q + 2'd1;
        // Completion is judged against the target of the level chosen this cycle.
        if (nxt == RAMP) begin
          tgt = target_of(level_d);
          if (duty_q == tgt)
            nxt = (tgt != 8'd0) ? RUN : IDLE;
          else if (tick)
            duty_d = ramp_to(duty_q, tgt);
        end
        if (nxt != RAMP)
          tick_d = '0;
      end
      RUN: begin
        if (bus.timer_expired) begin
          level_d = 2'd0;
          nxt     = RAMP;
        end else if (close_rd && level_q != 2'd0) begin
          nxt    = PROX;
          duty_d = '0;
        end else if (bus.btn_speed) begin
          level_d = level_q + 2'd1;
          nxt     = RAMP;
        end
      end
      PROX: begin
        duty_d = '0;
        far_d  = far_q;
        if (bus.timer_expired) begin
          level_d = 2'd0;
          nxt     = IDLE;
          far_d   = '0;
        end else if (far_rd) begin
          if (far_q == 2'd2) begin
            nxt   = RAMP;
            far_d = '0;
          end else
            far_d = far_q + 2'd1;
        end else if (near_rd)
          far_d = '0;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_p) begin
      cur     <= IDLE;
      level_q <= '0;
      duty_q  <= '0;
      tick_q  <= '0;
      far_q   <= '0;
      sw_q    <= 1'b0;
      led_q   <= '0;
    end else begin
      cur     <= nxt;
      level_q <= level_d;
      duty_q  <= duty_d;
      tick_q  <= tick_d;
      far_q   <= far_d;
      sw_q    <= (duty_d != 8'd0);
      led_q   <= led_of(level_d);
    end
  end

  assign bus.duty      = duty_q;
  assign bus.level     = level_q;
  assign bus.motor_sw  = sw_q;
  assign bus.motor_led = led_q;
  assign bus.state     = cur;

endmodule
